countdown_timer: RTL and testbench



---
 rtl/countdown_timer.sv | 118 +++++++++++
 tb/tb_countdown_timer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with start/busy/done handshake,
// a clock prescaler and optional auto-reload for periodic ticks.
module countdown_timer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           r_state, w_state_nx;
  logic [PW-1:0]    r_pre, w_pre_nx;
  logic [WIDTH-1:0] r_reload, w_reload_nx;
  logic             r_flag, w_flag_nx;
  logic [WIDTH-1:0] r_count, w_count_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic             w_tick;

  assign w_tick = (r_pre == PRE_LAST);

  // State and datapath registers; synchronous reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pre    <= '0;
      r_reload <= '0;
      r_flag   <= 1'b0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_pre    <= w_pre_nx;
      r_reload <= w_reload_nx;
      r_flag   <= w_flag_nx;
      r_count  <= w_count_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
    end
  end

  // Next-state and next-output logic; done is a one-cycle pulse by default.
  always_comb begin
    w_state_nx  = r_state;
    w_pre_nx    = r_pre;
    w_reload_nx = r_reload;
    w_flag_nx   = r_flag;
    w_count_nx  = r_count;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          if (load_value != '0) begin
            w_count_nx  = load_value;
            w_reload_nx = load_value;
            w_flag_nx   = auto_reload;
            w_pre_nx    = '0;
            w_busy_nx   = 1'b1;
            w_state_nx  = S_RUN;
          end else begin
            // Zero-length interval: complete immediately without running.
            w_count_nx = '0;
            w_done_nx  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          // Abort wins over a coincident tick; count freezes, no done.
          w_state_nx = S_IDLE;
          w_busy_nx  = 1'b0;
          w_pre_nx   = '0;
          w_flag_nx  = 1'b0;
        end else begin
          w_pre_nx = w_tick ? '0 : r_pre + PW'(1);
          if (w_tick) begin
            if (r_count > WIDTH'(1)) begin
              w_count_nx = r_count - WIDTH'(1);
            end else begin
              w_done_nx = 1'b1;
              if (r_flag) begin
                // Reload edge is itself a tick boundary, so pre is already 0.
                w_count_nx = r_reload;
              end else begin
                w_count_nx = '0;
                w_state_nx = S_IDLE;
                w_busy_nx  = 1'b0;
              end
            end
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer: one instance with
// PRESCALE=1 and one with PRESCALE=3, both WIDTH=4.
module tb_countdown_timer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] a_load, b_load;
  logic       a_start, a_stop, a_auto;
  logic       b_start, b_stop, b_auto;
  logic [3:0] a_count, b_count;
  logic       a_busy, a_done, b_busy, b_done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clock = ~clock;

  countdown_timer #(.WIDTH(4), .PRESCALE(1)) u_p1 (
    .clock      (clock),
    .reset      (reset),
    .load_value (a_load),
    .start      (a_start),
    .stop       (a_stop),
    .auto_reload(a_auto),
    .count      (a_count),
    .busy       (a_busy),
    .done       (a_done)
  );

  countdown_timer #(.WIDTH(4), .PRESCALE(3)) u_p3 (
    .clock      (clock),
    .reset      (reset),
    .load_value (b_load),
    .start      (b_start),
    .stop       (b_stop),
    .auto_reload(b_auto),
    .count      (b_count),
    .busy       (b_busy),
    .done       (b_done)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int c, input logic b, input logic d);
    chk({tag, ".count"}, {28'd0, a_count}, c);
    chk({tag, ".busy"},  {31'd0, a_busy},  {31'd0, b});
    chk({tag, ".done"},  {31'd0, a_done},  {31'd0, d});
  endtask

  initial begin
    reset = 1'b1;
    a_load = 4'd5; a_start = 1'b1; a_stop = 1'b0; a_auto = 1'b0;
    b_load = 4'd0; b_start = 1'b0; b_stop = 1'b0; b_auto = 1'b0;

    // Reset with start held high: nothing happens.
    step(); step(); step();
    chk_a("reset", 0, 1'b0, 1'b0);

    // One-shot, L=5: start accepted on the first edge after release.
    reset = 1'b0;
    step();
    chk_a("os5_n0", 5, 1'b1, 1'b0);
    a_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_a($sformatf("os5_n%0d", k), 5 - k, 1'b1, 1'b0);
    end
    step();
    chk_a("os5_end", 0, 1'b0, 1'b1);
    step();
    chk_a("os5_after", 0, 1'b0, 1'b0);

    // Auto-reload, L=3: period 3, sequence 3,2,1,3,...
    a_load = 4'd3; a_auto = 1'b1; a_start = 1'b1;
    step();
    chk_a("ar_n0", 3, 1'b1, 1'b0);
    a_start = 1'b0; a_auto = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk_a($sformatf("ar_n%0d", k), 3 - (k % 3), 1'b1, (k % 3) == 0);
    end
    // Stop while count=3: frozen, no done, stays idle.
    a_stop = 1'b1;
    step();
    chk_a("ar_stop", 3, 1'b0, 1'b0);
    a_stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_a($sformatf("ar_post%0d", k), 3, 1'b0, 1'b0);
    end

    // Zero-length interval.
    a_load = 4'd0; a_start = 1'b1;
    step();
    chk_a("zero", 0, 1'b0, 1'b1);
    a_start = 1'b0;
    step();
    chk_a("zero_after", 0, 1'b0, 1'b0);

    // Maximum interval L=15.
    a_load = 4'd15; a_start = 1'b1;
    step();
    chk_a("max_n0", 15, 1'b1, 1'b0);
    a_start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      chk_a($sformatf("max_n%0d", k), 15 - k, 1'b1, 1'b0);
    end
    step();
    chk_a("max_end", 0, 1'b0, 1'b1);

    // Stop coinciding with the final tick at count=1.
    a_load = 4'd2; a_start = 1'b1;
    step();
    chk_a("st1_n0", 2, 1'b1, 1'b0);
    a_start = 1'b0;
    step();
    chk_a("st1_n1", 1, 1'b1, 1'b0);
    a_stop = 1'b1;
    step();
    chk_a("st1_stop", 1, 1'b0, 1'b0);
    a_stop = 1'b0;
    step();
    chk_a("st1_after", 1, 1'b0, 1'b0);

    // Start held high across a whole one-shot run.
    a_load = 4'd2; a_start = 1'b1;
    step();
    chk_a("hold_n0", 2, 1'b1, 1'b0);
    step();
    chk_a("hold_n1", 1, 1'b1, 1'b0);
    step();
    chk_a("hold_done", 0, 1'b0, 1'b1);
    step();
    chk_a("hold_restart", 2, 1'b1, 1'b0);
    a_start = 1'b0;
    step();
    chk_a("hold_r1", 1, 1'b1, 1'b0);
    step();
    chk_a("hold_rdone", 0, 1'b0, 1'b1);

    // Reset mid-run at count=2.
    a_load = 4'd4; a_start = 1'b1;
    step();
    chk_a("rst_n0", 4, 1'b1, 1'b0);
    a_start = 1'b0;
    step();
    step();
    chk_a("rst_n2", 2, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    chk_a("rst_mid", 0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk_a("rst_after", 0, 1'b0, 1'b0);

    // Prescaled one-shot, PRESCALE=3, L=2: done exactly 6 cycles after start.
    b_load = 4'd2; b_start = 1'b1;
    step();
    chk("ps_n0.count", {28'd0, b_count}, 2);
    chk("ps_n0.busy",  {31'd0, b_busy},  1);
    b_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("ps_n%0d.count", k), {28'd0, b_count}, (k < 3) ? 2 : 1);
      chk($sformatf("ps_n%0d.busy", k),  {31'd0, b_busy},  1);
      chk($sformatf("ps_n%0d.done", k),  {31'd0, b_done},  0);
    end
    step();
    chk("ps_end.count", {28'd0, b_count}, 0);
    chk("ps_end.busy",  {31'd0, b_busy},  0);
    chk("ps_end.done",  {31'd0, b_done},  1);
    step();
    chk("ps_after.done", {31'd0, b_done}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
